// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the inst/data sram-like request arbiter: source tags
// and the default outstanding-request depth.
package sram_req_arbiter_pkg;

  localparam int OUTST_DEPTH_DEFAULT = 4;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

endpackage

// File: rtl/arb_tag_fifo.sv
// Small FIFO of source tags. It remembers which requester owns each accepted
// address so in-order responses can be routed back to that requester.
module arb_tag_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = OUTST_DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  src_e din,
  output logic full,
  output logic empty,
  output src_e head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  src_e             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem_q[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order statements execute in.
  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count and pointers define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like memory port between an instruction reader and a data
// requester: data has priority, with a starvation guard and a grant lock.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH = OUTST_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_unexpected
);

  src_e       grant;
  src_e       lock_src_q;
  logic       lock_q;
  logic       lock_hold;
  logic [1:0] starve_q;
  logic       accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  src_e       fifo_head;

  // NOTE: every comb output gets a value on all paths, so no latch is inferred.
  // A stalled grant stays put while its requester keeps req high.
  always_comb begin
    lock_hold = lock_q & ((lock_src_q == SRC_DATA) ? data_req : inst_req);
    if (lock_hold)
      grant = lock_src_q;
    else if (data_req && !(inst_req && starve_q == 2'd3))
      grant = SRC_DATA;
    else
      grant = SRC_INST;
  end

  // Outputs are gated with resetn so nothing handshakes while reset is held.
  assign mem_req      = resetn & (inst_req | data_req) & ~fifo_full;
  assign accept       = mem_req & mem_addr_ok;
  assign mem_addr     = (grant == SRC_DATA) ? data_addr  : inst_addr;
  assign mem_wen      = (grant == SRC_DATA) ? data_wen   : 4'h0;
  assign mem_wdata    = (grant == SRC_DATA) ? data_wdata : 32'h0;
  assign inst_addr_ok = accept & (grant == SRC_INST);
  assign data_addr_ok = accept & (grant == SRC_DATA);

  assign fifo_pop     = mem_data_ok & ~fifo_empty;
  assign inst_data_ok = resetn & fifo_pop & (fifo_head == SRC_INST);
  assign data_data_ok = resetn & fifo_pop & (fifo_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q         <= 1'b0;
      lock_src_q     <= SRC_INST;
      starve_q       <= 2'd0;
      err_unexpected <= 1'b0;
    end else begin
      lock_q     <= mem_req & ~mem_addr_ok;
      lock_src_q <= grant;
      // Saturates at 3 in case a locked data grant completes while guarded.
      if (!inst_req || inst_addr_ok)
        starve_q <= 2'd0;
      else if (data_addr_ok && starve_q != 2'd3)
        starve_q <= starve_q + 2'd1;
      if (mem_data_ok && fifo_empty)
        err_unexpected <= 1'b1;
    end
  end

  arb_tag_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (fifo_pop),
    .din    (grant),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

endmodule
